alu_result_stage: RTL and testbench



---
 rtl/alu_result_stage.sv | 102 ++++++++++
 tb/tb_alu_result_stage.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// Registered ALU result stage: derives zero/overflow/carry flags on the incoming
// result, presents them through a valid/ready handshake with a 2-entry skid buffer.
module alu_result_stage #(
    parameter int WIDTH     = 32,
    parameter int OVF_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     result,
    input  logic [2:0]           op,
    input  logic                 a_msb,
    input  logic                 bmux_msb,
    input  logic                 set_msb,
    input  logic                 cout,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_result,
    output logic [2:0]           out_op,
    output logic                 out_zero,
    output logic                 out_overflow,
    output logic                 out_carry,
    output logic [OVF_CNT_W-1:0] ovf_count
);

    function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Stage p0: flags derived combinationally from the upstream slices
    logic arith_p0, zero_p0, ovf_p0, carry_p0;
    assign arith_p0 = (op[1:0] == 2'b10);
    assign zero_p0  = (result == '0);
    assign ovf_p0   = arith_p0 & (a_msb == bmux_msb) & (set_msb != a_msb);
    assign carry_p0 = arith_p0 & cout;

    logic skid_valid;
    logic accept, load_out, load_skid, drain;

    assign in_ready  = ~skid_valid & ~reset;
    assign accept    = in_valid & in_ready;
    assign load_out  = accept & (~out_valid | out_ready);
    assign load_skid = accept & out_valid & ~out_ready;
    assign drain     = out_valid & out_ready;

    // Stage p1: skid entry, only written when the output register is stalled
    logic [WIDTH-1:0] skid_result_p1;
    logic [2:0]       skid_op_p1;
    logic             skid_zero_p1, skid_ovf_p1, skid_carry_p1;

    always_ff @(posedge clk) begin
        if (load_skid) begin
            skid_result_p1 <= result;
            skid_op_p1     <= op;
            skid_zero_p1   <= zero_p0;
            skid_ovf_p1    <= ovf_p0;
            skid_carry_p1  <= carry_p0;
        end
    end

    // Stage p1: output register, refilled from input or from the skid entry
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid    <= 1'b0;
            skid_valid   <= 1'b0;
            out_result   <= '0;
            out_op       <= '0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
            out_carry    <= 1'b0;
            ovf_count    <= '0;
        end else begin
            if (accept) begin
                if (load_out) begin
                    out_valid    <= 1'b1;
                    out_result   <= result;
                    out_op       <= op;
                    out_zero     <= zero_p0;
                    out_overflow <= ovf_p0;
                    out_carry    <= carry_p0;
                end else begin
                    skid_valid   <= 1'b1;
                end
            end else if (drain) begin
                if (skid_valid) begin
                    out_result   <= skid_result_p1;
                    out_op       <= skid_op_p1;
                    out_zero     <= skid_zero_p1;
                    out_overflow <= skid_ovf_p1;
                    out_carry    <= skid_carry_p1;
                    skid_valid   <= 1'b0;
                end else begin
                    out_valid    <= 1'b0;
                end
            end
            if (accept && ovf_p0)
                ovf_count <= sat_inc(ovf_count);
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; a second instance with a 2-bit counter
// shares all inputs to exercise counter saturation.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready, in_ready2;
    logic [31:0] result;
    logic [2:0]  op;
    logic        a_msb, bmux_msb, set_msb, cout;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_result, out_result2;
    logic [2:0]  out_op, out_op2;
    logic        out_zero, out_zero2, out_overflow, out_overflow2, out_carry, out_carry2;
    logic [15:0] ovf_count;
    logic [1:0]  sat_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    alu_result_stage #(.WIDTH(32), .OVF_CNT_W(16)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .result(result), .op(op), .a_msb(a_msb), .bmux_msb(bmux_msb),
        .set_msb(set_msb), .cout(cout), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_op(out_op), .out_zero(out_zero),
        .out_overflow(out_overflow), .out_carry(out_carry), .ovf_count(ovf_count)
    );

    alu_result_stage #(.WIDTH(32), .OVF_CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .result(result), .op(op), .a_msb(a_msb), .bmux_msb(bmux_msb),
        .set_msb(set_msb), .cout(cout), .out_valid(out_valid2), .out_ready(out_ready),
        .out_result(out_result2), .out_op(out_op2), .out_zero(out_zero2),
        .out_overflow(out_overflow2), .out_carry(out_carry2), .ovf_count(sat_count)
    );

    task automatic drive(input logic v, input logic [31:0] r, input logic [2:0] o,
                         input logic a, input logic b, input logic s, input logic c);
        in_valid = v; result = r; op = o; a_msb = a; bmux_msb = b; set_msb = s; cout = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_low got %b want 0", in_ready); end
        tick(); tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready_held got %b want 0", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests++; if (ovf_count !== 16'd0) begin fails++; $display("FAIL reset_ovf_count got %0d want 0", ovf_count); end
        tests++; if (out_result !== 32'd0 || out_op !== 3'd0 || out_zero !== 1'b0 || out_overflow !== 1'b0 || out_carry !== 1'b0) begin
            fails++; $display("FAIL reset_out_regs got %h/%b/%b%b%b want 0", out_result, out_op, out_zero, out_overflow, out_carry); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL post_reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_add_overflow();
        out_ready = 1'b1;
        drive(1'b1, 32'h8000_0000, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_result !== 32'h8000_0000 || out_op !== 3'b010) begin
            fails++; $display("FAIL add_data got v=%b r=%h op=%b want v=1 r=80000000 op=010", out_valid, out_result, out_op); end
        tests++; if (out_overflow !== 1'b1 || out_carry !== 1'b0 || out_zero !== 1'b0) begin
            fails++; $display("FAIL add_flags got ovf=%b c=%b z=%b want 1 0 0", out_overflow, out_carry, out_zero); end
        tests++; if (ovf_count !== 16'd1) begin fails++; $display("FAIL add_ovf_count got %0d want 1", ovf_count); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_drain got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_sub_zero();
        out_ready = 1'b1;
        drive(1'b1, 32'd0, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        tests++; if (out_zero !== 1'b1 || out_carry !== 1'b1 || out_overflow !== 1'b0 || out_op !== 3'b110) begin
            fails++; $display("FAIL sub_zero_flags got z=%b c=%b ovf=%b op=%b want 1 1 0 110", out_zero, out_carry, out_overflow, out_op); end
        drive(1'b1, 32'd0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b1);
        tick();
        in_valid = 1'b0;
        tests++; if (out_zero !== 1'b1 || out_carry !== 1'b0 || out_overflow !== 1'b0 || out_op !== 3'b000) begin
            fails++; $display("FAIL logic_op_flags got z=%b c=%b ovf=%b op=%b want 1 0 0 000", out_zero, out_carry, out_overflow, out_op); end
        tests++; if (ovf_count !== 16'd1) begin fails++; $display("FAIL sub_ovf_count got %0d want 1", ovf_count); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 32'd1, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tests++; if (out_valid !== 1'b1 || out_result !== 32'd1 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_first got v=%b r=%0d rdy=%b want 1 1 1", out_valid, out_result, in_ready); end
        result = 32'd2;
        tick();
        tests++; if (out_result !== 32'd1 || in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_skid_full got r=%0d rdy=%b want 1 0", out_result, in_ready); end
        result = 32'd3;
        tick();
        tests++; if (out_valid !== 1'b1 || out_result !== 32'd1 || out_op !== 3'b000 || in_ready !== 1'b0) begin
            fails++; $display("FAIL bp_hold got v=%b r=%0d op=%b rdy=%b want 1 1 000 0", out_valid, out_result, out_op, in_ready); end
        out_ready = 1'b1;
        tick();
        tests++; if (out_valid !== 1'b1 || out_result !== 32'd2 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_out2 got v=%b r=%0d rdy=%b want 1 2 1", out_valid, out_result, in_ready); end
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_result !== 32'd3) begin
            fails++; $display("FAIL bp_out3 got v=%b r=%0d want 1 3", out_valid, out_result); end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_empty got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_full_rate();
        logic [31:0] r;
        logic [2:0]  o;
        logic        a, b, s, c, e_ovf, e_carry;
        logic [15:0] e_cnt;
        int          bad;
        bad = 0;
        e_cnt = ovf_count;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            r = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            o = 3'($urandom_range(0, 7));
            a = 1'($urandom_range(0, 1)); b = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
            e_ovf   = (o[1:0] == 2'b10) && (a == b) && (s != a);
            e_carry = (o[1:0] == 2'b10) && c;
            if (e_ovf) e_cnt = e_cnt + 16'd1;
            drive(1'b1, r, o, a, b, s, c);
            tick();
            tests++;
            if (out_valid !== 1'b1 || out_result !== r || out_op !== o || out_zero !== (r == 32'd0)
                || out_overflow !== e_ovf || out_carry !== e_carry || ovf_count !== e_cnt || in_ready !== 1'b1) begin
                fails++;
                if (bad < 5)
                    $display("FAIL stream[%0d] got v=%b r=%h op=%b z=%b o=%b c=%b cnt=%0d want r=%h op=%b z=%b o=%b c=%b cnt=%0d",
                             i, out_valid, out_result, out_op, out_zero, out_overflow, out_carry, ovf_count,
                             r, o, (r == 32'd0), e_ovf, e_carry, e_cnt);
                bad++;
            end
        end
        in_valid = 1'b0;
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL stream_end got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic [1:0] e;
        reset = 1'b1; in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tests++; if (sat_count !== 2'd0) begin fails++; $display("FAIL sat_reset got %0d want 0", sat_count); end
        out_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 32'h8000_0000 + 32'(k), 3'b010, 1'b0, 1'b0, 1'b1, 1'b0);
            tick();
            e = (k >= 3) ? 2'd3 : 2'(k);
            tests++; if (sat_count !== e) begin fails++; $display("FAIL sat_count[%0d] got %0d want %0d", k, sat_count, e); end
        end
        in_valid = 1'b0;
        tick();
        tests++; if (sat_count !== 2'd3) begin fails++; $display("FAIL sat_hold got %0d want 3", sat_count); end
        out_ready = 1'b0;
        drive(1'b1, 32'hA, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        result = 32'hB;
        tick();
        tests++; if (in_ready2 !== 1'b0 || out_result2 !== 32'hA) begin
            fails++; $display("FAIL sat_skid_full got rdy=%b r=%h want 0 a", in_ready2, out_result2); end
        reset = 1'b1;
        tick();
        tests++; if (out_valid2 !== 1'b0 || out_valid !== 1'b0 || in_ready2 !== 1'b0 || sat_count !== 2'd0) begin
            fails++; $display("FAIL midreset got v=%b v1=%b rdy=%b cnt=%0d want 0 0 0 0", out_valid2, out_valid, in_ready2, sat_count); end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests++; if (out_valid2 !== 1'b0 || out_valid !== 1'b0) begin
                fails++; $display("FAIL stale_entry[%0d] got v=%b v1=%b want 0 0", k, out_valid2, out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_zero();
        test_backpressure();
        test_full_rate();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
